// File: rtl/memory_game_ctrl.sv
// rtl/memory_game_ctrl.sv - pair-matching sequencer for the 6x6 memory-card grid.
// Optional miss limit / game_over output enabled by defining MISS_LIMIT_EN.
module memory_game_ctrl #(
   parameter int NUM_CARDS   = 36,
   parameter int SHOW_CYCLES = 25000000,
   parameter int CNT_W       = 8,
   parameter int MAX_MISSES  = 20
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [5:0]           cursor,
   input  logic                 select,
   output logic [5:0]           board_addr,
   input  logic [5:0]           board_data,
   output logic [5:0]           selectedCard,
   output logic [5:0]           card1,
   output logic [5:0]           card2,
   output logic [NUM_CARDS-1:0] matched,
   output logic [5:0]           pairs_found,
   output logic [CNT_W-1:0]     attempts,
   output logic                 busy,
   output logic                 win
`ifdef MISS_LIMIT_EN
   ,
   output logic                 game_over
`endif
);

   localparam int TMR_W = $clog2(SHOW_CYCLES) + 1;
   localparam logic [5:0]       NONE      = 6'h3F;
   localparam logic [TMR_W-1:0] TMR_LOAD  = TMR_W'(SHOW_CYCLES - 1);
   localparam logic [5:0]       PAIRS_ALL = 6'(NUM_CARDS / 2);
   localparam logic [5:0]       CARD_LIM  = 6'(NUM_CARDS);

   typedef enum logic [2:0] {
      S_PICK1, S_WAIT1, S_PICK2, S_WAIT2, S_COMPARE, S_SHOW, S_CHECK, S_DONE
   } state_t;

   state_t                 r_state, w_state_nxt;
   logic [5:0]             r_card1, w_card1_nxt;
   logic [5:0]             r_card2, w_card2_nxt;
   logic [5:0]             r_addr, w_addr_nxt;
   logic [5:0]             r_val1, w_val1_nxt;
   logic [5:0]             r_val2, w_val2_nxt;
   logic [5:0]             r_sel;
   logic [NUM_CARDS-1:0]   r_matched, w_matched_nxt;
   logic [5:0]             r_pairs, w_pairs_nxt;
   logic [CNT_W-1:0]       r_attempts, w_attempts_nxt;
   logic [TMR_W-1:0]       r_timer, w_timer_nxt;
   logic                   r_busy, w_busy_nxt;
   logic                   r_win, w_win_nxt;
`ifdef MISS_LIMIT_EN
   logic [CNT_W-1:0]       r_misses, w_misses_nxt;
   logic                   r_game_over, w_game_over_nxt;
`endif

   logic [63:0]            w_matched_ext;
   logic                   w_sel_ok;
   logic [NUM_CARDS-1:0]   w_pair_mask;

   // Widen matched to 64 bits so any 6-bit cursor indexes it safely
   assign w_matched_ext = 64'(r_matched);
   assign w_sel_ok      = select && (cursor < CARD_LIM) && !w_matched_ext[cursor];
   assign w_pair_mask   = ({{(NUM_CARDS-1){1'b0}}, 1'b1} << r_card1)
                        | ({{(NUM_CARDS-1){1'b0}}, 1'b1} << r_card2);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= S_PICK1;
         r_card1     <= NONE;
         r_card2     <= NONE;
         r_addr      <= '0;
         r_val1      <= '0;
         r_val2      <= '0;
         r_sel       <= '0;
         r_matched   <= '0;
         r_pairs     <= '0;
         r_attempts  <= '0;
         r_timer     <= '0;
         r_busy      <= 1'b0;
         r_win       <= 1'b0;
`ifdef MISS_LIMIT_EN
         r_misses    <= '0;
         r_game_over <= 1'b0;
`endif
      end else begin
         r_state     <= w_state_nxt;
         r_card1     <= w_card1_nxt;
         r_card2     <= w_card2_nxt;
         r_addr      <= w_addr_nxt;
         r_val1      <= w_val1_nxt;
         r_val2      <= w_val2_nxt;
         r_sel       <= cursor;
         r_matched   <= w_matched_nxt;
         r_pairs     <= w_pairs_nxt;
         r_attempts  <= w_attempts_nxt;
         r_timer     <= w_timer_nxt;
         r_busy      <= w_busy_nxt;
         r_win       <= w_win_nxt;
`ifdef MISS_LIMIT_EN
         r_misses    <= w_misses_nxt;
         r_game_over <= w_game_over_nxt;
`endif
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_card1_nxt    = r_card1;
      w_card2_nxt    = r_card2;
      w_addr_nxt     = r_addr;
      w_val1_nxt     = r_val1;
      w_val2_nxt     = r_val2;
      w_matched_nxt  = r_matched;
      w_pairs_nxt    = r_pairs;
      w_attempts_nxt = r_attempts;
      w_timer_nxt    = r_timer;
      w_busy_nxt     = r_busy;
      w_win_nxt      = r_win;
`ifdef MISS_LIMIT_EN
      w_misses_nxt    = r_misses;
      w_game_over_nxt = r_game_over;
`endif
      case (r_state)
         S_PICK1: begin
            if (w_sel_ok) begin
               w_card1_nxt = cursor;
               w_addr_nxt  = cursor;
               w_state_nxt = S_WAIT1;
            end
         end
         S_WAIT1: begin
            w_val1_nxt  = board_data;
            w_state_nxt = S_PICK2;
         end
         S_PICK2: begin
            if (w_sel_ok && (cursor != r_card1)) begin
               w_card2_nxt = cursor;
               w_addr_nxt  = cursor;
               w_busy_nxt  = 1'b1;
               w_state_nxt = S_WAIT2;
            end
         end
         S_WAIT2: begin
            w_val2_nxt  = board_data;
            w_state_nxt = S_COMPARE;
         end
         S_COMPARE: begin
            if (r_attempts != {CNT_W{1'b1}})
               w_attempts_nxt = r_attempts + CNT_W'(1);
            if (r_val1 == r_val2) begin
               w_matched_nxt = r_matched | w_pair_mask;
               w_pairs_nxt   = r_pairs + 6'd1;
               w_card1_nxt   = NONE;
               w_card2_nxt   = NONE;
               w_busy_nxt    = 1'b0;
               w_state_nxt   = S_CHECK;
            end else begin
               w_timer_nxt = TMR_LOAD;
`ifdef MISS_LIMIT_EN
               if (r_misses != {CNT_W{1'b1}})
                  w_misses_nxt = r_misses + CNT_W'(1);
`endif
               w_state_nxt = S_SHOW;
            end
         end
         S_SHOW: begin
            if (r_timer == '0) begin
               w_card1_nxt = NONE;
               w_card2_nxt = NONE;
               w_busy_nxt  = 1'b0;
               w_state_nxt = S_PICK1;
`ifdef MISS_LIMIT_EN
               if (r_misses >= CNT_W'(MAX_MISSES)) begin
                  w_game_over_nxt = 1'b1;
                  w_state_nxt     = S_DONE;
               end
`endif
            end else begin
               w_timer_nxt = r_timer - TMR_W'(1);
            end
         end
         S_CHECK: begin
            if (r_pairs == PAIRS_ALL) begin
               w_win_nxt   = 1'b1;
               w_state_nxt = S_DONE;
            end else begin
               w_state_nxt = S_PICK1;
            end
         end
         S_DONE: begin
            w_state_nxt = S_DONE;
         end
         default: w_state_nxt = S_PICK1;
      endcase
   end

   assign board_addr   = r_addr;
   assign selectedCard = r_sel;
   assign card1        = r_card1;
   assign card2        = r_card2;
   assign matched      = r_matched;
   assign pairs_found  = r_pairs;
   assign attempts     = r_attempts;
   assign busy         = r_busy;
   assign win          = r_win;
`ifdef MISS_LIMIT_EN
   assign game_over    = r_game_over;
`endif

endmodule

// File: tb/tb_memory_game_ctrl.sv
// tb/tb_memory_game_ctrl.sv - directed scoreboard bench for memory_game_ctrl.
module tb_memory_game_ctrl;
   localparam int NC = 36;
   localparam int SC = 4;
   localparam int CW = 8;
   localparam int MM = 2;

   logic          clock = 1'b0;
   logic          reset;
   logic [5:0]    cursor;
   logic          select;
   logic [5:0]    board_addr, board_data, selectedCard, card1, card2, pairs_found;
   logic [NC-1:0] matched;
   logic [CW-1:0] attempts;
   logic          busy, win;
`ifdef MISS_LIMIT_EN
   logic          game_over;
`endif

   logic [5:0] mem [0:63];
   assign board_data = mem[board_addr];

   always #5 clock = ~clock;

   memory_game_ctrl #(
      .NUM_CARDS(NC), .SHOW_CYCLES(SC), .CNT_W(CW), .MAX_MISSES(MM)
   ) dut (
      .clock(clock), .reset(reset), .cursor(cursor), .select(select),
      .board_addr(board_addr), .board_data(board_data),
      .selectedCard(selectedCard), .card1(card1), .card2(card2),
      .matched(matched), .pairs_found(pairs_found), .attempts(attempts),
      .busy(busy), .win(win)
`ifdef MISS_LIMIT_EN
      , .game_over(game_over)
`endif
   );

   typedef struct packed {
      logic [5:0]    c1;
      logic [5:0]    c2;
      logic [5:0]    pf;
      logic [CW-1:0] at;
      logic          bz;
      logic          wn;
      logic [NC-1:0] mt;
   } snap_t;

   snap_t  exp_q[$];
   string  tag_q[$];
   int     n_tests = 0;
   int     n_fail  = 0;

   logic [NC-1:0] m_matched;
   int            m_pairs, m_att;
   logic [5:0]    pa [0:17];
   logic [5:0]    pb [0:17];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic pulse(input logic [5:0] c);
      cursor = c;
      select = 1'b1;
      tick;
      select = 1'b0;
   endtask

   task automatic pop_chk;
      snap_t e;
      string t;
      n_tests++;
      assert (exp_q.size() > 0) else begin
         n_fail++;
         $error("FAIL scoreboard_empty: got 0 entries expected 1");
      end
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         chk($sformatf("%s.card1", t), card1, e.c1);
         chk($sformatf("%s.card2", t), card2, e.c2);
         chk($sformatf("%s.pairs", t), pairs_found, e.pf);
         chk($sformatf("%s.attempts", t), attempts, e.at);
         chk($sformatf("%s.busy", t), busy, e.bz);
         chk($sformatf("%s.win", t), win, e.wn);
         chk($sformatf("%s.matched", t), matched, e.mt);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, ".card1"}, card1, 6'h3F);
      chk({tag, ".card2"}, card2, 6'h3F);
      chk({tag, ".matched"}, matched, '0);
      chk({tag, ".pairs"}, pairs_found, 0);
      chk({tag, ".attempts"}, attempts, 0);
      chk({tag, ".addr"}, board_addr, 0);
      chk({tag, ".sel"}, selectedCard, 0);
      chk({tag, ".busy"}, busy, 0);
      chk({tag, ".win"}, win, 0);
`ifdef MISS_LIMIT_EN
      chk({tag, ".game_over"}, game_over, 0);
`endif
   endtask

   // Second pick plus compare; leaves time just after the COMPARE edge
   task automatic second(input string tag, input logic [5:0] a, input logic [5:0] b, input bit is_match);
      snap_t s;
      m_att++;
      if (is_match) begin
         m_matched[a] = 1'b1;
         m_matched[b] = 1'b1;
         m_pairs++;
      end
      s.c1 = is_match ? 6'h3F : a;
      s.c2 = is_match ? 6'h3F : b;
      s.pf = 6'(m_pairs);
      s.at = CW'(m_att);
      s.bz = !is_match;
      s.wn = 1'b0;
      s.mt = m_matched;
      exp_q.push_back(s);
      tag_q.push_back(tag);
      pulse(b);
      chk({tag, ".card2_pick"}, card2, b);
      chk({tag, ".busy_pick"}, busy, 1);
      tick;
      tick;
      pop_chk();
   endtask

   task automatic play_pair(input string tag, input logic [5:0] a, input logic [5:0] b, input bit is_match);
      pulse(a);
      chk({tag, ".card1_pick"}, card1, a);
      chk({tag, ".addr_pick"}, board_addr, a);
      tick;
      second(tag, a, b, is_match);
   endtask

   initial begin
      cursor = 6'd0;
      select = 1'b0;
      reset  = 1'b1;
      m_matched = '0;
      m_pairs = 0;
      m_att = 0;
      for (int i = 0; i < 64; i++) mem[i] = 6'd0;
      for (int k = 0; k < 7; k++) begin
         pa[k] = 6'(k);
         pb[k] = 6'(k + 7);
         mem[k]     = (k == 0) ? 6'd5 : (k == 1) ? 6'd2 : (k == 2) ? 6'd3 : 6'(k + 10);
         mem[k + 7] = mem[k];
      end
      for (int j = 0; j < 11; j++) begin
         pa[j + 7] = 6'(14 + 2 * j);
         pb[j + 7] = 6'(15 + 2 * j);
         mem[14 + 2 * j] = 6'(20 + j);
         mem[15 + 2 * j] = 6'(20 + j);
      end

      tick;
      tick;
      chk_reset_vals("reset");
      cursor = 6'd17;
      reset = 1'b0;
      tick;
      chk("selected_follow", selectedCard, 6'd17);

      play_pair("match_0_7", 6'd0, 6'd7, 1'b1);
      tick;
      chk("match_0_7.win", win, 0);

      play_pair("miss_1_2", 6'd1, 6'd2, 1'b0);
      for (int i = 0; i < SC - 1; i++) begin
         if (i == 0) pulse(6'd3);
         else tick;
         chk($sformatf("show%0d.card1", i), card1, 6'd1);
         chk($sformatf("show%0d.card2", i), card2, 6'd2);
         chk($sformatf("show%0d.busy", i), busy, 1);
      end
      tick;
      chk("show_end.card1", card1, 6'h3F);
      chk("show_end.card2", card2, 6'h3F);
      chk("show_end.busy", busy, 0);
      chk("show_end.matched", matched, m_matched);
      chk("show_end.attempts", attempts, CW'(m_att));

      pulse(6'd3);
      chk("after_show.card1", card1, 6'd3);
      chk("after_show.addr", board_addr, 6'd3);
      tick;
      pulse(6'd3);
      chk("same_card.card2", card2, 6'h3F);
      chk("same_card.busy", busy, 0);
      pulse(6'd40);
      chk("range.card2", card2, 6'h3F);
      chk("range.addr", board_addr, 6'd3);
      pulse(6'd0);
      chk("matched_sel.card2", card2, 6'h3F);
      chk("matched_sel.attempts", attempts, CW'(m_att));
      second("match_3_10", 6'd3, 6'd10, 1'b1);
      tick;
      pulse(6'd40);
      chk("p1_range.card1", card1, 6'h3F);
      pulse(6'd7);
      chk("p1_matched.card1", card1, 6'h3F);
      chk("p1_matched.addr", board_addr, 6'd10);

      play_pair("miss_rst", 6'd1, 6'd2, 1'b0);
      tick;
      tick;
      #2;
      reset = 1'b1;
      #1;
      chk_reset_vals("async_reset");
      tick;
      reset = 1'b0;
      m_matched = '0;
      m_pairs = 0;
      m_att = 0;
      tick;

      for (int k = 0; k < 18; k++) begin
         play_pair($sformatf("win_pair%0d", k), pa[k], pb[k], 1'b1);
         tick;
         if (k < 17) chk($sformatf("win_pair%0d.win", k), win, 0);
      end
      chk("win.flag", win, 1);
      chk("win.pairs", pairs_found, 6'd18);
      chk("win.matched", matched, {NC{1'b1}});
      pulse(6'd5);
      chk("done.card1", card1, 6'h3F);
      chk("done.addr", board_addr, 6'd35);
      chk("done.win", win, 1);

`ifdef MISS_LIMIT_EN
      reset = 1'b1;
      tick;
      reset = 1'b0;
      m_matched = '0;
      m_pairs = 0;
      m_att = 0;
      tick;
      for (int m = 0; m < MM; m++) begin
         play_pair($sformatf("limit%0d", m), 6'd1, 6'd2, 1'b0);
         for (int i = 0; i < SC; i++) tick;
         chk($sformatf("limit%0d.card1", m), card1, 6'h3F);
         chk($sformatf("limit%0d.game_over", m), game_over, (m == MM - 1) ? 1 : 0);
      end
      chk("limit.win", win, 0);
      pulse(6'd0);
      chk("limit_done.card1", card1, 6'h3F);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
